api_tx_arb: RTL and testbench

- Work scheduler in front of the api TX FIFO push port.
- Shares the single FIFO write port between REQ_NUM requesters, e.g. the wishbone slave and a work-replay engine.
- Grants are whole-work: WORK_LEN words, never interleaved, and only when the FIFO has room for a complete work.
- Round-robin fairness; a single flush input aborts any transfer in progress.

---
 rtl/api_define.sv | 11 +
 rtl/api_rr_pick.sv | 25 ++
 rtl/api_tx_arb.sv | 107 ++++++++++
 tb/tb_api_tx_arb.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/api_define.sv
// api_define: shared constants, FSM encoding and round-robin helper for the api TX schedulers.
package api_define;
  localparam int WORK_LEN   = 23;
  localparam int FIFO_DEPTH = 1024;
  localparam int CNT_W      = 11;
  localparam int API_NUM    = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, SETTLE = 2'd2} arb_state_e;
  function automatic logic [2:0] rr_inc(input logic [2:0] p, input int n);
    return (int'(p) == n - 1) ? 3'd0 : p + 3'd1;
  endfunction
endpackage

// File: rtl/api_rr_pick.sv
// api_rr_pick: first asserted request at or after rr_ptr_i, modulo N.
module api_rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   rr_ptr_i,
  output logic         found_o,
  output logic [2:0]   index_o
);
  logic [3:0] j;
  always_comb begin
    found_o = 1'b0;
    index_o = rr_ptr_i;
    j = '0;
    // walk offsets from farthest to nearest so the nearest valid index wins
    for (int i = N - 1; i >= 0; i--) begin
      j = 4'(rr_ptr_i) + 4'(i);
      j = (j >= 4'(N)) ? j - 4'(N) : j;
      if ((req_i & (N'(1) << j)) != '0) begin
        found_o = 1'b1;
        index_o = j[2:0];
      end
    end
  end
endmodule

// File: rtl/api_tx_arb.sv
// api_tx_arb: whole-work round-robin scheduler in front of the api TX FIFO push port.
module api_tx_arb import api_define::*; #(
  parameter int REQ_NUM    = API_NUM,
  parameter int WORK_LEN   = api_define::WORK_LEN,
  parameter int FIFO_DEPTH = api_define::FIFO_DEPTH,
  parameter int CNT_W      = api_define::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [REQ_NUM-1:0]    req_valid,
  input  logic [REQ_NUM*32-1:0] req_data,
  output logic [REQ_NUM-1:0]    req_ready,
  input  logic [CNT_W-1:0]      txcnt,
  input  logic                  txfull,
  output logic                  txfifo_push,
  output logic [31:0]           txfifo_din,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic                  work_done
);
  localparam int WCW = $clog2(WORK_LEN);
  arb_state_e state_q, state_d;
  logic [2:0] grant_q, grant_d, rr_q, rr_d, pick_idx;
  logic [WCW-1:0] cnt_q, cnt_d;
  logic [CNT_W:0] free;
  logic pick_found, space, sel_v, accept, last, push_q;
  logic [31:0] sel_d, din_q;
  api_rr_pick #(.N(REQ_NUM)) u_pick (
    .req_i   (req_valid),
    .rr_ptr_i(rr_q),
    .found_o (pick_found),
    .index_o (pick_idx)
  );
  // a txcnt above FIFO_DEPTH goes negative here and is treated as no room
  assign free  = (CNT_W+1)'(FIFO_DEPTH) - {1'b0, txcnt};
  assign space = !free[CNT_W] && free >= (CNT_W+1)'(WORK_LEN);
  always_comb begin
    sel_v = 1'b0;
    sel_d = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (grant_q == 3'(i)) begin
        sel_v = req_valid[i];
        sel_d = req_data[32*i +: 32];
      end
    end
  end
  assign accept = state_q == XFER && sel_v && !txfull;
  assign last   = cnt_q == WCW'(WORK_LEN - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      rr_d    = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (pick_found && space) begin
          state_d = XFER;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
        XFER: if (accept) begin
          cnt_d = cnt_q + WCW'(1);
          if (last) begin
            state_d = SETTLE;
            rr_d    = rr_inc(grant_q, REQ_NUM);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    busy      = state_q == XFER;
    work_done = accept && last && !flush;
    for (int i = 0; i < REQ_NUM; i++) req_ready[i] = busy && !txfull && grant_q == 3'(i);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_q <= 1'b0;
      din_q  <= '0;
    end else begin
      push_q <= accept && !flush;
      if (accept) din_q <= sel_d;
    end
  end
  assign txfifo_push = push_q;
  assign txfifo_din  = din_q;
  assign grant_id    = grant_q;
endmodule

// File: tb/tb_api_tx_arb.sv
// tb_api_tx_arb: directed table vectors plus hand sequences for whole-work arbitration.
module tb_api_tx_arb;
  localparam int WL = 23;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, txfull = 1'b0;
  logic [1:0] req_valid = '0, req_ready;
  logic [63:0] req_data = '0;
  logic [10:0] txcnt = '0;
  logic txfifo_push, busy, work_done;
  logic [31:0] txfifo_din;
  logic [2:0] grant_id;
  int n_chk = 0, n_fail = 0;
  logic [31:0] tag [2];
  int w [2], wn [2];
  logic p_acc = 1'b0;
  logic [31:0] p_dat = '0;
  typedef struct {
    logic [1:0] v; logic [31:0] d0, d1; logic [10:0] tc; logic full, fl;
    logic [1:0] er; logic eb, ed, ep; logic [31:0] edin; int eg;
  } vec_t;
  vec_t tbl [13];

  api_tx_arb #(.REQ_NUM(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .txcnt(txcnt), .txfull(txfull), .txfifo_push(txfifo_push),
    .txfifo_din(txfifo_din), .grant_id(grant_id), .busy(busy), .work_done(work_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dat(input int i);
    return tag[i] | (32'(wn[i]) << 8) | 32'(w[i]);
  endfunction

  task automatic step(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [10:0] tc, input logic full, input logic fl,
                      input logic [1:0] er, input logic eb, input logic ed, input logic ep,
                      input logic [31:0] edin, input int eg, input string nm);
    @(negedge clk);
    req_valid = v; req_data = {d1, d0}; txcnt = tc; txfull = full; flush = fl;
    #1;
    chk({nm, ".ready"}, 32'(req_ready), 32'(er));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
    chk({nm, ".done"}, 32'(work_done), 32'(ed));
    chk({nm, ".push"}, 32'(txfifo_push), 32'(ep));
    if (ep) chk({nm, ".din"}, txfifo_din, edin);
    if (eg >= 0) chk({nm, ".grant"}, 32'(grant_id), 32'(eg));
    p_acc = |(v & er) && !fl;
    p_dat = er[0] ? d0 : d1;
  endtask

  task automatic run_work(input int g, input logic [1:0] m, input int st_at, input int st_len);
    int k = 0, s = 0;
    logic [1:0] v, er;
    logic acc;
    er = 2'(1 << g);
    step(m, dat(0), dat(1), 0, 0, 0, 2'b00, 0, 0, p_acc, p_dat, -1, "idle");
    while (k < WL) begin
      v = (k == st_at + 1 && s < st_len) ? m & ~er : m;
      acc = |(v & er);
      step(v, dat(0), dat(1), 0, 0, 0, er, 1, acc && k == WL - 1, p_acc, p_dat, g, "xfer");
      if (acc) begin k++; w[g]++; end else s++;
    end
    wn[g]++;
    w[g] = 0;
    step(m, dat(0), dat(1), 0, 0, 0, 2'b00, 0, 0, p_acc, p_dat, g, "settle");
  endtask

  initial begin
    tbl[0]  = '{2'b00, 32'h0,  32'h0,  11'd1002, 0, 0, 2'b00, 0, 0, 0, 32'h0,  0};
    tbl[1]  = '{2'b01, 32'h11, 32'h0,  11'd1002, 0, 0, 2'b00, 0, 0, 0, 32'h0,  0};
    tbl[2]  = '{2'b01, 32'h11, 32'h0,  11'd1002, 0, 0, 2'b00, 0, 0, 0, 32'h0,  0};
    tbl[3]  = '{2'b01, 32'h11, 32'h0,  11'd1001, 0, 0, 2'b00, 0, 0, 0, 32'h0,  0};
    tbl[4]  = '{2'b00, 32'h11, 32'h0,  11'd1001, 0, 0, 2'b01, 1, 0, 0, 32'h0,  0};
    tbl[5]  = '{2'b01, 32'h11, 32'h0,  11'd1001, 1, 0, 2'b00, 1, 0, 0, 32'h0,  0};
    tbl[6]  = '{2'b01, 32'h11, 32'h0,  11'd1001, 0, 0, 2'b01, 1, 0, 0, 32'h0,  0};
    tbl[7]  = '{2'b01, 32'h12, 32'h0,  11'd1001, 0, 1, 2'b01, 1, 0, 1, 32'h11, 0};
    tbl[8]  = '{2'b00, 32'h0,  32'h0,  11'd0,    0, 0, 2'b00, 0, 0, 0, 32'h0,  0};
    tbl[9]  = '{2'b10, 32'h0,  32'h21, 11'd0,    0, 0, 2'b00, 0, 0, 0, 32'h0,  0};
    tbl[10] = '{2'b10, 32'h0,  32'h21, 11'd0,    0, 0, 2'b10, 1, 0, 0, 32'h0,  1};
    tbl[11] = '{2'b00, 32'h0,  32'h0,  11'd0,    0, 1, 2'b10, 1, 0, 1, 32'h21, 1};
    tbl[12] = '{2'b00, 32'h0,  32'h0,  11'd0,    0, 0, 2'b00, 0, 0, 0, 32'h0,  1};
    w[0] = 0; w[1] = 0; wn[0] = 0; wn[1] = 0;
    tag[0] = 32'h1000; tag[1] = 32'hB000_0000;
    #12;
    chk("rst.push", 32'(txfifo_push), 32'd0);
    chk("rst.din", txfifo_din, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.done", 32'(work_done), 32'd0);
    chk("rst.grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 13; i++)
      step(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].tc, tbl[i].full, tbl[i].fl, tbl[i].er,
           tbl[i].eb, tbl[i].ed, tbl[i].ep, tbl[i].edin, tbl[i].eg, $sformatf("vec%0d", i));
    // single requester, full work of 0x1000..0x1016
    run_work(0, 2'b01, -1, 0);
    // abort on word 10, then restart from word 0 with rr_ptr cleared
    tag[0] = 32'h2000;
    step(2'b01, dat(0), dat(1), 0, 0, 0, 2'b00, 0, 0, p_acc, p_dat, -1, "fl.idle");
    for (int k = 0; k <= 10; k++) begin
      step(2'b01, dat(0), dat(1), 0, 0, k == 10, 2'b01, 1, 0, p_acc, p_dat, 0, "fl.xfer");
      w[0]++;
    end
    w[0] = 0;
    tag[0] = 32'hA000_0000;
    for (int i = 0; i < 6; i++) run_work(i % 2, 2'b11, -1, 0);
    // requester 0 stalls 5 cycles after word 10 while requester 1 waits
    run_work(0, 2'b11, 10, 5);
    // async reset with a push in flight
    tag[0] = 32'h3000; w[0] = 0; wn[0] = 0;
    step(2'b01, dat(0), dat(1), 0, 0, 0, 2'b00, 0, 0, p_acc, p_dat, -1, "ar.idle");
    for (int k = 0; k < 3; k++) begin
      step(2'b01, dat(0), dat(1), 0, 0, 0, 2'b01, 1, 0, p_acc, p_dat, 0, "ar.xfer");
      w[0]++;
    end
    @(posedge clk);
    #1;
    chk("arst.pre_push", 32'(txfifo_push), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst.push", 32'(txfifo_push), 32'd0);
    chk("arst.din", txfifo_din, 32'd0);
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.ready", 32'(req_ready), 32'd0);
    chk("arst.grant", 32'(grant_id), 32'd0);
    #1 rst = 1'b0;
    w[0] = 0;
    p_acc = 1'b0;
    run_work(0, 2'b11, -1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
